wb_regfile: RTL and testbench

Write-back stage and architectural register file of the pipelined RV32I core. It consumes the MEM/WB pipeline register outputs: control bits, ALU result, raw data-memory word, PC+4 and destination register. It selects and load-formats the write-back value and commits it to a 32×32 register file. It also serves the decode stage's two combinational read ports with same-cycle write-through bypass, and keeps a retired-instruction counter.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/regfile.sv | 55 +++++
 rtl/wb_regfile.sv | 91 +++++++++
 tb/tb_wb_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: write-back result select encoding, load funct3 codes and
// architectural register indices used by the WB stage.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_ZERO = 2'b11
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned REG_A0 = 10;

endpackage

// File: rtl/regfile.sv
// Architectural register file: async-clear storage, single write port, x0 hard-wired to zero,
// and two combinational read ports with same-cycle write-through bypass.
module regfile
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] ra1_i,
  input  logic [ADDR_WIDTH-1:0] ra2_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o,
  output logic [DATA_WIDTH-1:0] a0_o
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [NumRegs];
  logic                  wr_commit;

  // x0 is never written, so its entry stays at its reset value of zero.
  assign wr_commit = we_i && (waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_commit) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (ra1_i != '0) begin
      rd1_o = (wr_commit && (ra1_i == waddr_i)) ? wdata_i : rf_q[ra1_i];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i != '0) begin
      rd2_o = (wr_commit && (ra2_i == waddr_i)) ? wdata_i : rf_q[ra2_i];
    end
  end

  assign a0_o = rf_q[REG_A0];

endmodule

// File: rtl/wb_regfile.sv
// RV32I write-back stage: load formatting, result selection, retired-instruction counter,
// and the architectural register file with bypassed decode read ports.
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidW,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [2:0]            LoadFunct3W,
  input  logic [DATA_WIDTH-1:0] ALUResultW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] PCPlus4W,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [CNT_WIDTH-1:0]  instret
);

  logic [1:0]            byte_off;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;
  result_src_t           res_src;
  logic [CNT_WIDTH-1:0]  instret_q;

  assign byte_off  = ALUResultW[1:0];
  assign load_byte = ReadDataW[{byte_off, 3'b000} +: 8];
  // Halfword lanes are picked by off[1] alone; misalignment is not trapped here.
  assign load_half = byte_off[1] ? ReadDataW[31:16] : ReadDataW[15:0];

  always_comb begin
    load_data = ReadDataW;
    case (LoadFunct3W)
      F3_LB:   load_data = {{(DATA_WIDTH - 8){load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{(DATA_WIDTH - 16){load_half[15]}}, load_half};
      F3_LBU:  load_data = {{(DATA_WIDTH - 8){1'b0}}, load_byte};
      F3_LHU:  load_data = {{(DATA_WIDTH - 16){1'b0}}, load_half};
      default: load_data = ReadDataW;
    endcase
  end

  assign res_src = result_src_t'(ResultSrcW);

  always_comb begin
    ResultW = '0;
    unique case (res_src)
      RES_ALU:  ResultW = ALUResultW;
      RES_MEM:  ResultW = load_data;
      RES_PC4:  ResultW = PCPlus4W;
      RES_ZERO: ResultW = '0;
      default:  ResultW = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (ValidW) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign instret = instret_q;

  regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (RegWriteW && ValidW),
    .waddr_i (RdW),
    .wdata_i (ResultW),
    .ra1_i   (A1),
    .ra2_i   (A2),
    .rd1_o   (RD1),
    .rd2_o   (RD2),
    .a0_o    (a0)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic against an
// array-based architectural model; a second narrow-counter instance exercises instret wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidW, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [2:0]  LoadFunct3W;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW, A1, A2;
  logic [31:0] RD1, RD2, ResultW, a0;
  logic [63:0] instret;
  logic [31:0] RD1_n, RD2_n, ResultW_n, a0_n;
  logic [3:0]  instret_n;

  logic [31:0] ref_rf [32];
  logic [63:0] ref_instret;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .LoadFunct3W(LoadFunct3W), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .a0(a0), .instret(instret)
  );

  wb_regfile #(.CNT_WIDTH(4)) u_dut_narrow (
    .clk(clk), .rst_n(rst_n), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .LoadFunct3W(LoadFunct3W), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW), .A1(A1), .A2(A2),
    .RD1(RD1_n), .RD2(RD2_n), .ResultW(ResultW_n), .a0(a0_n), .instret(instret_n)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input int unsigned off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    case (ResultSrcW)
      2'd0:    return ALUResultW;
      2'd1:    return m_load(ReadDataW, LoadFunct3W, 32'(ALUResultW) % 4);
      2'd2:    return PCPlus4W;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_writes();
    return ValidW && RegWriteW && (RdW != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_writes() && a == RdW) return m_result();
    return ref_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    ref_instret = 64'h0;
  endtask

  task automatic idle_inputs();
    ValidW = 0; RegWriteW = 0; ResultSrcW = 2'd0; LoadFunct3W = 3'd2;
    ALUResultW = 0; ReadDataW = 0; PCPlus4W = 0; RdW = 0; A1 = 0; A2 = 0;
  endtask

  // One clock edge: model commits with the inputs held across it, then return at negedge.
  task automatic cycle();
    @(posedge clk);
    if (m_writes()) ref_rf[RdW] = m_result();
    if (ValidW) ref_instret = ref_instret + 64'd1;
    @(negedge clk);
  endtask

  task automatic set_write(input logic [4:0] rd, input logic [31:0] val);
    ValidW = 1; RegWriteW = 1; ResultSrcW = 2'd0; ALUResultW = val; RdW = rd;
  endtask

  logic [31:0] ld_f3  [5] = '{32'd0, 32'd4, 32'd1, 32'd5, 32'd2};
  logic [31:0] ld_off [5] = '{32'd3, 32'd3, 32'd2, 32'd1, 32'd2};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};
  logic [63:0] saved_cnt;

  initial begin
    idle_inputs();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    A1 = 5'd5;
    #1;
    check_eq("reset_rd1", 64'(RD1), 64'h0);
    check_eq("reset_a0", 64'(a0), 64'h0);
    check_eq("reset_instret", instret, 64'h0);

    // 17 valid bubbles from reset: narrow counter wraps to 1.
    ValidW = 1;
    repeat (17) cycle();
    ValidW = 0;
    #1;
    check_eq("wrap_instret4", 64'(instret_n), 64'h1);
    check_eq("instret_17", instret, ref_instret);

    ReadDataW = 32'h80FF_7F01; ResultSrcW = 2'd1;
    for (int i = 0; i < 5; i++) begin
      LoadFunct3W = ld_f3[i][2:0];
      ALUResultW  = 32'h1000 | ld_off[i];
      #1;
      check_eq($sformatf("load_fmt_%0d", i), 64'(ResultW), 64'(ld_exp[i]));
    end

    set_write(5'd7, 32'hDEAD_BEEF); A1 = 5'd7; A2 = 5'd7;
    #1;
    check_eq("wt_rd1", 64'(RD1), 64'hDEAD_BEEF);
    check_eq("wt_rd2", 64'(RD2), 64'hDEAD_BEEF);
    cycle();
    RegWriteW = 0; ValidW = 0;
    #1;
    check_eq("wt_stored", 64'(RD1), 64'hDEAD_BEEF);

    set_write(5'd0, 32'hFFFF_FFFF); A1 = 5'd0;
    #1;
    check_eq("x0_bypass", 64'(RD1), 64'h0);
    cycle();
    check_eq("x0_stored", 64'(RD1), 64'h0);

    set_write(5'd3, 32'h0000_0033);
    cycle();
    ValidW = 0; RegWriteW = 1; RdW = 5'd3; ALUResultW = 32'hBAD; A1 = 5'd3;
    saved_cnt = instret;
    cycle();
    RegWriteW = 0;
    #1;
    check_eq("bubble_x3", 64'(RD1), 64'h33);
    check_eq("bubble_instret", instret, saved_cnt);

    ValidW = 1; RegWriteW = 1; ResultSrcW = 2'd2; PCPlus4W = 32'h104; RdW = 5'd10;
    ALUResultW = 32'h5555; saved_cnt = instret;
    #1;
    check_eq("pc4_result", 64'(ResultW), 64'h104);
    cycle();
    ValidW = 0; RegWriteW = 0;
    #1;
    check_eq("a0_pc4", 64'(a0), 64'h104);
    check_eq("pc4_instret", instret, saved_cnt + 64'd1);

    for (int n = 0; n < 400; n++) begin
      ValidW      = ($urandom_range(0, 3) != 0);
      RegWriteW   = ($urandom_range(0, 3) != 0);
      ResultSrcW  = 2'($urandom_range(0, 3));
      LoadFunct3W = 3'($urandom_range(0, 7));
      ALUResultW  = $urandom;
      ReadDataW   = $urandom;
      PCPlus4W    = $urandom;
      RdW         = (n % 9 == 0) ? 5'd10 : 5'($urandom_range(0, 31));
      A1          = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
      A2          = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
      #1;
      check_eq("rnd_result", 64'(ResultW), 64'(m_result()));
      check_eq("rnd_rd1", 64'(RD1), 64'(m_read(A1)));
      check_eq("rnd_rd2", 64'(RD2), 64'(m_read(A2)));
      check_eq("rnd_a0", 64'(a0), 64'(ref_rf[10]));
      check_eq("rnd_instret", instret, ref_instret);
      check_eq("rnd_instret4", 64'(instret_n), 64'(ref_instret[3:0]));
      cycle();
    end

    // Mid-cycle async reset with a write to x6 pending.
    set_write(5'd5, 32'h1234_5678);
    cycle();
    set_write(5'd6, 32'h6666_6666); A1 = 5'd5; A2 = 5'd6;
    #1;
    check_eq("pre_rst_x5", 64'(RD1), 64'h1234_5678);
    #2;
    rst_n = 0;
    #1;
    check_eq("rst_rd1", 64'(RD1), 64'h0);
    check_eq("rst_a0", 64'(a0), 64'h0);
    check_eq("rst_instret", instret, 64'h0);
    @(posedge clk);
    @(negedge clk);
    model_clear();
    ValidW = 0; RegWriteW = 0;
    #1;
    check_eq("rst_discard_x6", 64'(RD2), 64'h0);
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
